fifth_mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read 16-bit SRAM between three users: the fifth core's instruction fetch, the fifth core's data access, and a host/loader port.
Sequences each CPU step as fetch, then optional data access, then release. The core is frozen through cpu_stall, which acts as a global enable on every core register, including reboot.
Host accesses are interleaved only between CPU steps, with a bounded burst length. Sits between the fifth core, the SRAM macro and the debug/loader bridge.

---
 rtl/fifth_pkg.sv | 33 +++
 rtl/fifth_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_fifth_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifth_pkg.sv
// Shared definitions for the fifth core and its memory arbiter: word/address
// sizes, arbiter state encoding and the core's opcode/ALU field constants.
package fifth_pkg;

   localparam int FIFTH_MEM_AW = 13;
   localparam int FIFTH_WORD_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      FLATCH,
      DATA,
      DLATCH,
      RUN,
      HOST
   } arb_state_t;

   // Bit 15 set marks an immediate-push instruction; the low 15 bits are the value.
   localparam logic [15:0] OP_IMMED_MASK = 16'h8000;
   localparam logic [3:0]  ALU_ADD       = 4'h0;
   localparam logic [3:0]  ALU_SUB       = 4'h1;
   localparam logic [3:0]  ALU_AND       = 4'h2;
   localparam logic [3:0]  ALU_OR        = 4'h3;
   localparam logic [3:0]  ALU_XOR       = 4'h4;
   localparam logic [3:0]  ALU_NOT       = 4'h5;
   localparam logic [3:0]  ALU_SHL       = 4'h6;
   localparam logic [3:0]  ALU_SHR       = 4'h7;

   function automatic logic is_immed(input logic [FIFTH_WORD_W-1:0] instr);
      return (instr & OP_IMMED_MASK) != '0;
   endfunction

endpackage

// File: rtl/fifth_mem_arbiter.sv
// Single-port SRAM arbiter for the fifth core (fetch, data) and a host loader port.
// Optional CPU write protection below PROT_LIMIT: define FIFTH_ARB_WPROT_EN.
module fifth_mem_arbiter
   import fifth_pkg::*;
#(
   parameter int                MEM_AW         = FIFTH_MEM_AW,
   parameter int                HOST_BURST_MAX = 4,
   parameter logic [MEM_AW-1:0] PROT_LIMIT     = 13'h0400
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [MEM_AW-1:0]       cpu_code_addr,
   output logic [FIFTH_WORD_W-1:0] cpu_instr,
   input  logic [FIFTH_WORD_W-1:0] cpu_data_addr,
   input  logic                    cpu_data_we,
   input  logic                    cpu_data_re,
   input  logic [FIFTH_WORD_W-1:0] cpu_data_wdata,
   output logic [FIFTH_WORD_W-1:0] cpu_data_rdata,
   output logic                    cpu_stall,
   input  logic                    host_halt,
   input  logic                    host_req,
   input  logic                    host_we,
   input  logic [MEM_AW-1:0]       host_addr,
   input  logic [FIFTH_WORD_W-1:0] host_wdata,
   output logic                    host_gnt,
   output logic                    host_rvalid,
   output logic [FIFTH_WORD_W-1:0] host_rdata,
   output logic [MEM_AW-1:0]       sram_addr,
   output logic                    sram_we,
   output logic [FIFTH_WORD_W-1:0] sram_wdata,
   input  logic [FIFTH_WORD_W-1:0] sram_rdata,
   output logic                    wprot_err
);

   localparam int             BW          = $clog2(HOST_BURST_MAX + 1);
   localparam logic [BW-1:0]  BURST_MAX_C = BW'(HOST_BURST_MAX);

   arb_state_t               state_q, state_d, arb_state;
   logic [BW-1:0]            burst_cnt_q, burst_cnt_d, arb_cnt;
   logic [FIFTH_WORD_W-1:0]  cpu_instr_q, cpu_instr_d;
   logic [FIFTH_WORD_W-1:0]  cpu_data_rdata_q, cpu_data_rdata_d;
   logic [FIFTH_WORD_W-1:0]  host_rdata_q, host_rdata_d;
   logic                     host_rvalid_q, host_rvalid_d;
   logic                     wprot_err_q, wprot_err_d;
   logic [MEM_AW-1:0]        data_addr;
   logic                     prot_hit;
   logic                     unused_addr_hi;

   assign data_addr      = cpu_data_addr[MEM_AW-1:0];
   assign unused_addr_hi = ^cpu_data_addr[FIFTH_WORD_W-1:MEM_AW];

`ifdef FIFTH_ARB_WPROT_EN
   assign prot_hit = cpu_data_we && (data_addr < PROT_LIMIT);
`else
   logic [MEM_AW-1:0] unused_prot_limit;
   assign unused_prot_limit = PROT_LIMIT;
   assign prot_hit          = 1'b0;
`endif

   // Decision taken whenever the FSM leaves IDLE, RUN or HOST.
   // The count saturates so an unbounded halted burst cannot wrap it.
   always_comb begin
      arb_state = IDLE;
      arb_cnt   = burst_cnt_q;
      if (host_req && (host_halt || (burst_cnt_q < BURST_MAX_C))) begin
         arb_state = HOST;
         arb_cnt   = (burst_cnt_q == BURST_MAX_C) ? burst_cnt_q : burst_cnt_q + BW'(1);
      end else if (!host_halt) begin
         arb_state = FETCH;
         arb_cnt   = '0;
      end
   end

   always_comb begin
      state_d          = state_q;
      burst_cnt_d      = burst_cnt_q;
      cpu_instr_d      = cpu_instr_q;
      cpu_data_rdata_d = cpu_data_rdata_q;
      host_rvalid_d    = 1'b0;
      wprot_err_d      = wprot_err_q;
      sram_addr        = '0;
      sram_we          = 1'b0;
      sram_wdata       = '0;
      host_gnt         = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            state_d     = arb_state;
            burst_cnt_d = arb_cnt;
         end
         FETCH: begin
            sram_addr = cpu_code_addr;
            state_d   = FLATCH;
         end
         FLATCH: begin
            cpu_instr_d = sram_rdata;
            state_d     = (cpu_data_we || cpu_data_re) ? DATA : RUN;
         end
         DATA: begin
            sram_addr = data_addr;
            if (cpu_data_we) begin
               // A protected write still finishes the step; only the strobe is dropped.
               sram_we     = !prot_hit;
               sram_wdata  = cpu_data_wdata;
               wprot_err_d = wprot_err_q | prot_hit;
               state_d     = RUN;
            end else begin
               state_d = DLATCH;
            end
         end
         DLATCH: begin
            cpu_data_rdata_d = sram_rdata;
            state_d          = RUN;
         end
         HOST: begin
            host_gnt      = 1'b1;
            sram_addr     = host_addr;
            sram_we       = host_we;
            sram_wdata    = host_wdata;
            host_rvalid_d = !host_we;
            state_d       = arb_state;
            burst_cnt_d   = arb_cnt;
         end
         default: state_d = IDLE;
      endcase
   end

   // Host read data is passed straight through in its rvalid cycle and held afterwards.
   assign host_rdata_d = host_rvalid_q ? sram_rdata : host_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         burst_cnt_q      <= '0;
         cpu_instr_q      <= '0;
         cpu_data_rdata_q <= '0;
         host_rdata_q     <= '0;
         host_rvalid_q    <= 1'b0;
         wprot_err_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         burst_cnt_q      <= burst_cnt_d;
         cpu_instr_q      <= cpu_instr_d;
         cpu_data_rdata_q <= cpu_data_rdata_d;
         host_rdata_q     <= host_rdata_d;
         host_rvalid_q    <= host_rvalid_d;
         wprot_err_q      <= wprot_err_d;
      end
   end

   assign cpu_stall      = (state_q != RUN);
   assign cpu_instr      = cpu_instr_q;
   assign cpu_data_rdata = cpu_data_rdata_q;
   assign host_rvalid    = host_rvalid_q;
   assign host_rdata     = host_rdata_d;
   assign wprot_err      = wprot_err_q;

endmodule

// File: tb/tb_fifth_mem_arbiter.sv
// Bench for fifth_mem_arbiter: SRAM model plus a word-level reference memory;
// CPU steps and host accesses are checked against step lengths and data rules.
module tb_fifth_mem_arbiter;

   localparam logic [12:0] PROT = 13'h0400;
`ifdef FIFTH_ARB_WPROT_EN
   localparam bit WPROT = 1'b1;
`else
   localparam bit WPROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] cpu_code_addr;
   logic [15:0] cpu_instr;
   logic [15:0] cpu_data_addr;
   logic        cpu_data_we, cpu_data_re;
   logic [15:0] cpu_data_wdata, cpu_data_rdata;
   logic        cpu_stall, host_halt, host_req, host_we;
   logic [12:0] host_addr;
   logic [15:0] host_wdata;
   logic        host_gnt, host_rvalid;
   logic [15:0] host_rdata;
   logic [12:0] sram_addr;
   logic        sram_we;
   logic [15:0] sram_wdata, sram_rdata;
   logic        wprot_err;

   int total = 0;
   int bad   = 0;

   logic [15:0] salt;
   logic [15:0] mem     [0:8191];
   logic        wr_flag [0:8191];
   logic [15:0] ref_mem [0:8191];
   logic        ref_wr  [0:8191];
   logic        bd_we;
   logic [12:0] bd_addr;
   logic [15:0] bd_data;
   logic [15:0] exp_rd;
   logic        exp_err;

   fifth_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_code_addr(cpu_code_addr), .cpu_instr(cpu_instr),
      .cpu_data_addr(cpu_data_addr), .cpu_data_we(cpu_data_we), .cpu_data_re(cpu_data_re),
      .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata), .cpu_stall(cpu_stall),
      .host_halt(host_halt), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .sram_addr(sram_addr), .sram_we(sram_we),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .wprot_err(wprot_err)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input logic [12:0] a);
      logic [15:0] t;
      t = {3'b000, a};
      return (t * 16'h9E37) ^ salt;
   endfunction

   // Synchronous-read SRAM; unwritten words read back a salted address pattern.
   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr]     <= bd_data;
         wr_flag[bd_addr] <= 1'b1;
      end else if (sram_we) begin
         mem[sram_addr]     <= sram_wdata;
         wr_flag[sram_addr] <= 1'b1;
      end
      sram_rdata <= wr_flag[sram_addr] ? mem[sram_addr] : pat(sram_addr);
   end

   function automatic logic [15:0] ref_rd(input logic [12:0] a);
      return ref_wr[a] ? ref_mem[a] : pat(a);
   endfunction

   task automatic ref_set(input logic [12:0] a, input logic [15:0] d);
      ref_mem[a] = d;
      ref_wr[a]  = 1'b1;
   endtask

   task automatic preload(input logic [12:0] a, input logic [15:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
      ref_set(a, d);
   endtask

   task automatic cpu_idle();
      cpu_data_we = 1'b0;
      cpu_data_re = 1'b0;
   endtask

   // Entered just after the edge that starts FETCH (extra=1 when an IDLE cycle precedes it).
   task automatic do_step(input logic [12:0] code, input logic [15:0] daddr, input logic we,
                          input logic re, input logic [15:0] wd, input int extra);
      int          n, wcnt, exp_len;
      logic [12:0] a, fetch_a, raddr, waddr;
      logic [15:0] wdat, exp_instr;
      logic        prot;
      cpu_code_addr = code; cpu_data_addr = daddr;
      cpu_data_we = we; cpu_data_re = re; cpu_data_wdata = wd;
      a         = daddr[12:0];
      prot      = WPROT && we && (a < PROT);
      exp_len   = extra + (we ? 4 : (re ? 5 : 3));
      exp_instr = ref_rd(code);
      if (re && !we) exp_rd = ref_rd(a);
      n = 0; wcnt = 0; fetch_a = '1; raddr = '1; waddr = '0; wdat = '0;
      do begin
         @(negedge clk);
         n++;
         if (n == extra + 1) fetch_a = sram_addr;
         if (n == extra + 3) raddr = sram_addr;
         if (sram_we) begin wcnt++; waddr = sram_addr; wdat = sram_wdata; end
      end while (cpu_stall && n < 16);
      total++; if (n !== exp_len) begin bad++; $display("FAIL step_len got=%0d exp=%0d", n, exp_len); end
      total++; if (fetch_a !== code) begin bad++; $display("FAIL fetch_addr got=%h exp=%h", fetch_a, code); end
      total++; if (cpu_instr !== exp_instr) begin bad++; $display("FAIL cpu_instr got=%h exp=%h", cpu_instr, exp_instr); end
      total++; if (cpu_data_rdata !== exp_rd) begin bad++; $display("FAIL cpu_rdata got=%h exp=%h", cpu_data_rdata, exp_rd); end
      if (re && !we) begin
         total++; if (raddr !== a) begin bad++; $display("FAIL read_addr got=%h exp=%h", raddr, a); end
      end
      total++; if (wcnt !== ((we && !prot) ? 1 : 0)) begin bad++; $display("FAIL write_pulses got=%0d we=%0b prot=%0b", wcnt, we, prot); end
      if (we && wcnt == 1) begin
         total++; if (waddr !== a || wdat !== wd) begin bad++; $display("FAIL write_data got=%h/%h exp=%h/%h", waddr, wdat, a, wd); end
      end
      if (we && !prot) ref_set(a, wd);
      if (prot) exp_err = 1'b1;
      total++; if (wprot_err !== exp_err) begin bad++; $display("FAIL wprot_err got=%b exp=%b", wprot_err, exp_err); end
      @(posedge clk); #1;
   endtask

   task automatic sync_run();
      int n;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (!cpu_stall) break;
      end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL sync_run got stall=%b exp=0", cpu_stall); end
      @(posedge clk); #1;
   endtask

   task automatic host_access(input logic we, input logic [12:0] addr, input logic [15:0] wd);
      int          n;
      logic [15:0] exp;
      cpu_idle();
      host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!host_gnt && n < 20);
      host_req = 1'b0;
      total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL host_gnt_wait got=%b exp=1", host_gnt); end
      exp = ref_rd(addr);
      if (we) ref_set(addr, wd);
      @(negedge clk);
      total++; if (host_rvalid !== !we) begin bad++; $display("FAIL host_rvalid got=%b exp=%b", host_rvalid, !we); end
      if (!we) begin
         total++; if (host_rdata !== exp) begin bad++; $display("FAIL host_rdata got=%h exp=%h", host_rdata, exp); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got=%b exp=1", cpu_stall); end
      total++; if (host_gnt !== 1'b0 || host_rvalid !== 1'b0) begin bad++; $display("FAIL rst_host got=%b%b exp=00", host_gnt, host_rvalid); end
      total++; if (sram_we !== 1'b0 || sram_addr !== 13'h0) begin bad++; $display("FAIL rst_sram got=%b/%h exp=0/0", sram_we, sram_addr); end
      total++; if (cpu_instr !== 16'h0 || cpu_data_rdata !== 16'h0) begin bad++; $display("FAIL rst_cpu_regs got=%h/%h exp=0/0", cpu_instr, cpu_data_rdata); end
      total++; if (host_rdata !== 16'h0 || wprot_err !== 1'b0) begin bad++; $display("FAIL rst_misc got=%h/%b exp=0/0", host_rdata, wprot_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_boot();
      reset = 1'b1;
      do_step(13'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1);
      total++; if (cpu_instr !== 16'h8005) begin bad++; $display("FAIL boot_instr got=%h exp=8005", cpu_instr); end
   endtask

   task automatic test_read_step();
      do_step(13'h1, 16'h0100, 1'b0, 1'b1, 16'h0, 0);
      total++; if (cpu_data_rdata !== 16'hBEEF) begin bad++; $display("FAIL read_beef got=%h exp=beef", cpu_data_rdata); end
   endtask

   task automatic test_write_step();
      do_step(13'h5, 16'h0200, 1'b1, 1'b0, 16'h1234, 0);
      host_access(1'b0, 13'h0200, 16'h0);
      host_access(1'b1, 13'h0207, 16'h5A5A);
      host_access(1'b0, 13'h0207, 16'h0);
   endtask

   task automatic test_host_saturation();
      int          run, gap, runs;
      bit          first_gap, stall_seen;
      logic        prev_rd, g;
      logic [12:0] prev_a;
      sync_run();
      cpu_idle();
      host_req = 1'b1; host_we = 1'($urandom);
      host_addr = 13'h1F00 + 13'($urandom_range(0, 7)); host_wdata = 16'($urandom);
      run = 0; gap = 0; runs = 0; first_gap = 1'b1; stall_seen = 1'b0; prev_rd = 1'b0; prev_a = '0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         total++; if (host_rvalid !== prev_rd) begin bad++; $display("FAIL sat_rvalid got=%b exp=%b", host_rvalid, prev_rd); end
         if (prev_rd) begin
            total++; if (host_rdata !== ref_rd(prev_a)) begin bad++; $display("FAIL sat_rdata got=%h exp=%h", host_rdata, ref_rd(prev_a)); end
         end
         prev_rd = 1'b0;
         g = host_gnt;
         if (g) begin
            if (gap > 0) begin
               if (!first_gap) begin
                  total++; if (gap !== 3 || !stall_seen) begin bad++; $display("FAIL sat_cpu_gap got=%0d/%b exp=3/1", gap, stall_seen); end
               end
               first_gap = 1'b0; gap = 0; stall_seen = 1'b0;
            end
            run++;
            prev_rd = !host_we; prev_a = host_addr;
            if (host_we) ref_set(host_addr, host_wdata);
         end else begin
            if (run > 0) begin
               runs++;
               total++; if (run !== 4) begin bad++; $display("FAIL sat_burst got=%0d exp=4", run); end
               run = 0;
            end
            gap++;
            if (!cpu_stall) stall_seen = 1'b1;
         end
         @(posedge clk); #1;
         if (g) begin
            host_we = 1'($urandom);
            host_addr = 13'h1F00 + 13'($urandom_range(0, 7)); host_wdata = 16'($urandom);
         end
      end
      host_req = 1'b0;
      @(negedge clk);
      if (host_gnt && host_we) ref_set(host_addr, host_wdata);
      total++; if (runs < 5) begin bad++; $display("FAIL sat_runs got=%0d exp>=5", runs); end
      @(posedge clk); #1;
   endtask

   task automatic test_host_halt();
      int n, lows, gnts;
      sync_run();
      cpu_code_addr = 13'($urandom); cpu_data_addr = 16'h0100;
      cpu_data_we = 1'b0; cpu_data_re = 1'b1;
      exp_rd = ref_rd(13'h0100);
      @(negedge clk);
      host_halt = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (cpu_stall && n < 10);
      total++; if (n !== 4) begin bad++; $display("FAIL halt_finish got=%0d exp=4", n); end
      total++; if (cpu_data_rdata !== exp_rd) begin bad++; $display("FAIL halt_rdata got=%h exp=%h", cpu_data_rdata, exp_rd); end
      @(posedge clk); #1;
      cpu_idle();
      lows = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (!cpu_stall || sram_addr !== 13'h0) lows++;
      end
      total++; if (lows !== 0) begin bad++; $display("FAIL halt_no_fetch got=%0d exp=0", lows); end
      @(posedge clk); #1;
      host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1F00;
      gnts = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (host_gnt) gnts++;
      end
      host_req = 1'b0;
      total++; if (gnts !== 9) begin bad++; $display("FAIL halt_host_gnts got=%0d exp=9", gnts); end
      @(posedge clk); #1;
      host_halt = 1'b0;
   endtask

   task automatic test_wprot();
      sync_run();
      do_step(13'($urandom), 16'h0010, 1'b1, 1'b0, 16'($urandom), 0);
      do_step(13'($urandom), 16'h0400, 1'b1, 1'b0, 16'($urandom), 0);
      total++; if (wprot_err !== WPROT) begin bad++; $display("FAIL wprot_sticky got=%b exp=%b", wprot_err, WPROT); end
      host_access(1'b0, 13'h0010, 16'h0);
      host_access(1'b0, 13'h0400, 16'h0);
   endtask

   task automatic test_random_steps();
      sync_run();
      for (int i = 0; i < 30; i++)
         do_step(13'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0),
                 1'($urandom), 16'($urandom), 0);
   endtask

   task automatic test_reset_mid();
      int n;
      sync_run();
      cpu_code_addr = 13'($urandom); cpu_data_addr = 16'h0100;
      cpu_data_we = 1'b0; cpu_data_re = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (cpu_stall !== 1'b1 || sram_addr !== 13'h0) begin bad++; $display("FAIL midrst_state got=%b/%h exp=1/0", cpu_stall, sram_addr); end
      total++; if (cpu_instr !== 16'h0 || cpu_data_rdata !== 16'h0) begin bad++; $display("FAIL midrst_regs got=%h/%h exp=0/0", cpu_instr, cpu_data_rdata); end
      exp_rd = 16'h0; exp_err = 1'b0;
      @(posedge clk); #1;
      cpu_idle();
      host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1F01;
      @(posedge clk); #1;
      reset = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!host_gnt && n < 10);
      total++; if (n !== 2) begin bad++; $display("FAIL midrst_gnt_lat got=%0d exp=2", n); end
      reset = 1'b0; host_req = 1'b0;
      #1;
      total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL midrst_gnt got=%b exp=0", host_gnt); end
      @(negedge clk);
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got=%b exp=0", host_rvalid); end
      @(posedge clk); #1;
      reset = 1'b1;
      do_step(13'($urandom), 16'h0100, 1'b0, 1'b1, 16'h0, 1);
   endtask

   initial begin
      reset = 1'b0; salt = 16'($urandom);
      cpu_code_addr = '0; cpu_data_addr = '0; cpu_data_we = 1'b0; cpu_data_re = 1'b0;
      cpu_data_wdata = '0; host_halt = 1'b0; host_req = 1'b0; host_we = 1'b0;
      host_addr = '0; host_wdata = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      exp_rd = 16'h0; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      preload(13'h0000, 16'h8005);
      preload(13'h0100, 16'hBEEF);
      test_reset();
      test_boot();
      test_read_step();
      test_write_step();
      test_host_saturation();
      test_host_halt();
      test_wprot();
      test_random_steps();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
